// File: rtl/quant_ctrl_if.sv
// Accumulator-in and result-out valid/ready streams of the quant sequencer.
// The master side is the producer of accumulators and consumer of results.
interface quant_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/quant_ctrl.sv
// Per-channel requantization sequencer: parameter table, fixed-latency
// pipe tracking and credit-protected output FIFO.
module quant_ctrl #(
  parameter int CH_MAX     = 256,
  parameter int ADDR_W     = 8,
  parameter int QUANT_LAT  = 4,
  parameter int OBUF_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   ch_num,
  input  logic [15:0]       pix_num,
  output logic              busy,
  output logic              done,
  input  logic              prm_we,
  input  logic [ADDR_W-1:0] prm_addr,
  input  logic [15:0]       prm_scale,
  input  logic [3:0]        prm_shift,
  input  logic [7:0]        prm_zp,
  output logic              prm_err,
  quant_ctrl_if.slave       bus,
  output logic [17:0]       q_acc,
  output logic [15:0]       q_scale,
  output logic [3:0]        q_shift,
  output logic [7:0]        q_zp,
  input  logic [7:0]        q_result
);
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int PW = $clog2(OBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_n;

  logic [27:0]       tbl [CH_MAX];
  logic [8:0]        fifo [OBUF_DEPTH];
  logic [ADDR_W:0]   ch_num_q;
  logic [15:0]       pix_num_q;
  logic [ADDR_W-1:0] ch_idx;
  logic [15:0]       pix_idx;
  logic [QUANT_LAT:0] sr_vld;
  logic [QUANT_LAT:0] sr_last;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     cnt;
  logic [CW:0]       used;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              bad_q;
  logic              go;
  logic              bad;
  logic              hs;
  logic              ch_end;
  logic              fin;
  logic              push;
  logic              pop;
  logic              drained;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign go = start && state == IDLE && ch_num != '0 &&
              pix_num != '0 && ch_num <= (ADDR_W+1)'(CH_MAX);
  assign bad = start && state == IDLE && !go;

  assign used = {1'b0, inflight} + {1'b0, cnt};
  assign bus.in_ready = state == RUN &&
                        used < (CW+1)'(OBUF_DEPTH);
  assign hs = bus.in_valid && bus.in_ready;

  assign ch_end = {1'b0, ch_idx} == ch_num_q - 1'b1;
  assign fin = hs && ch_end && pix_idx == pix_num_q - 16'd1;

  assign push = sr_vld[QUANT_LAT];
  assign pop = bus.out_valid && bus.out_ready;
  assign drained = state == DRAIN && inflight == '0 && cnt == '0;

  assign done = drained || bad_q;
  assign busy = state != IDLE && !drained;

  assign bus.out_valid = cnt != '0;
  assign {bus.out_last, bus.out_data} = fifo[rd_ptr];

  // Next-state decode for the layer sequencer.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go) state_n = RUN;
      RUN:     if (fin) state_n = DRAIN;
      DRAIN:   if (drained) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Layer state, counters and sticky parameter-write error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bad_q     <= 1'b0;
      prm_err   <= 1'b0;
      ch_num_q  <= '0;
      pix_num_q <= '0;
      ch_idx    <= '0;
      pix_idx   <= '0;
    end else begin
      state <= state_n;
      bad_q <= bad;
      if (start && state == IDLE)
        prm_err <= 1'b0;
      else if (prm_we && state != IDLE)
        prm_err <= 1'b1;
      if (go) begin
        ch_num_q  <= ch_num;
        pix_num_q <= pix_num;
        ch_idx    <= '0;
        pix_idx   <= '0;
      end else if (hs) begin
        if (ch_end) begin
          ch_idx  <= '0;
          pix_idx <= pix_idx + 16'd1;
        end else begin
          ch_idx <= ch_idx + 1'b1;
        end
      end
    end
  end

  // Track results in the quant pipe and the credits they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_vld   <= '0;
      sr_last  <= '0;
      inflight <= '0;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      sr_vld   <= {sr_vld[QUANT_LAT-1:0], hs};
      sr_last  <= {sr_last[QUANT_LAT-1:0], fin};
      inflight <= inflight + CW'(hs) - CW'(push);
      cnt      <= cnt + CW'(push) - CW'(pop);
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
    end
  end

  // Present an accepted accumulator with its channel's parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_acc   <= '0;
      q_scale <= '0;
      q_shift <= '0;
      q_zp    <= '0;
    end else if (hs) begin
      q_acc <= bus.in_data;
      {q_scale, q_shift, q_zp} <= tbl[ch_idx];
    end
  end

  // Parameter table; only writable between layers, survives reset.
  always_ff @(posedge clk) begin
    if (prm_we && state == IDLE)
      tbl[prm_addr] <= {prm_scale, prm_shift, prm_zp};
  end

  // Capture pipe results with their last tag.
  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= {sr_last[QUANT_LAT], q_result};
  end
endmodule

// File: tb/tb_quant_ctrl.sv
// Directed bench for quant_ctrl with a behavioural quant pipe
// and a scoreboard of expected results.
module tb_quant_ctrl;
  localparam int QL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  ch_num = '0;
  logic [15:0] pix_num = '0;
  logic        busy;
  logic        done;
  logic        prm_we = 1'b0;
  logic [7:0]  prm_addr = '0;
  logic [15:0] prm_scale = '0;
  logic [3:0]  prm_shift = '0;
  logic [7:0]  prm_zp = '0;
  logic        prm_err;
  logic [17:0] q_acc;
  logic [15:0] q_scale;
  logic [3:0]  q_shift;
  logic [7:0]  q_zp;
  logic [7:0]  q_result;
  logic [7:0]  pipe [QL];

  quant_ctrl_if qif ();

  quant_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .ch_num(ch_num), .pix_num(pix_num),
    .busy(busy), .done(done),
    .prm_we(prm_we), .prm_addr(prm_addr),
    .prm_scale(prm_scale), .prm_shift(prm_shift),
    .prm_zp(prm_zp), .prm_err(prm_err),
    .bus(qif),
    .q_acc(q_acc), .q_scale(q_scale),
    .q_shift(q_shift), .q_zp(q_zp),
    .q_result(q_result)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] qf(input logic [17:0] a,
                                    input logic [27:0] e);
    logic signed [33:0] p;
    p = $signed(a) * $signed(e[27:12]);
    p = p >>> e[11:8];
    return p[7:0] + e[7:0];
  endfunction

  always @(posedge clk) begin
    pipe[0] <= qf(q_acc, {q_scale, q_shift, q_zp});
    for (int i = 1; i < QL; i++) pipe[i] <= pipe[i-1];
  end
  assign q_result = pipe[QL-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [27:0] tm [256];
  logic [8:0] exq [$];
  int m_ch, m_pix, m_chn, m_pixn;
  int n_hs, n_out, done_cnt, done_cyc, last_cyc;
  bit pend;
  logic [17:0] p_acc;
  logic [27:0] p_ent;
  int vm, om;
  int we_at = -1;
  int sneak_at = -1;
  bit go_req;
  logic [8:0] go_ch;
  logic [15:0] go_pix;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prm_write(input int a, input logic [15:0] sc,
                           input logic [3:0] sh, input logic [7:0] zp);
    @(negedge clk);
    prm_we = 1'b1;
    prm_addr = 8'(a);
    prm_scale = sc;
    prm_shift = sh;
    prm_zp = zp;
    @(negedge clk);
    prm_we = 1'b0;
    tm[a] = {sc, sh, zp};
  endtask

  task automatic step();
    logic [8:0] e;
    bool_last: begin end
    @(negedge clk);
    cyc++;
    if (pend) begin
      chk("q_acc", 32'(q_acc), 32'(p_acc));
      chk("q_scale", 32'(q_scale), 32'(p_ent[27:12]));
      chk("q_shift", 32'(q_shift), 32'(p_ent[11:8]));
      chk("q_zp", 32'(q_zp), 32'(p_ent[7:0]));
      pend = 1'b0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", 32'(busy), 32'd0);
    end
    start = go_req || (cyc == sneak_at);
    ch_num = (cyc == sneak_at) ? 9'd1 : go_ch;
    pix_num = go_pix;
    go_req = 1'b0;
    if (we_at >= 0) prm_we = (cyc == we_at);
    qif.in_valid = (vm == 2) ? 1'($urandom_range(0, 1)) : (vm == 1);
    qif.in_data = 18'($urandom);
    qif.out_ready = (om == 2) ? 1'($urandom_range(0, 1)) : (om == 1);
    #1;
    if (qif.in_valid && qif.in_ready) begin
      e[8] = (m_ch == m_chn - 1) && (m_pix == m_pixn - 1);
      e[7:0] = qf(qif.in_data, tm[m_ch]);
      exq.push_back(e);
      pend = 1'b1;
      p_acc = qif.in_data;
      p_ent = tm[m_ch];
      n_hs++;
      if (m_ch == m_chn - 1) begin
        m_ch = 0;
        m_pix++;
      end else begin
        m_ch++;
      end
    end
    if (qif.out_valid && qif.out_ready) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL out_spurious: got %0h expected none", qif.out_data);
      end else begin
        e = exq.pop_front();
        chk("out_data", 32'(qif.out_data), 32'(e[7:0]));
        chk("out_last", 32'(qif.out_last), 32'(e[8]));
        n_out++;
        if (qif.out_last) begin
          last_cyc = cyc;
          chk("busy_at_last", 32'(busy), 32'd1);
        end
      end
    end
  endtask

  task automatic run_layer(input int chn, input int pixn, input int stall);
    int sv;
    m_ch = 0; m_pix = 0; m_chn = chn; m_pixn = pixn;
    n_hs = 0; n_out = 0; done_cnt = 0;
    done_cyc = -1; last_cyc = -1;
    exq.delete();
    go_req = 1'b1;
    go_ch = 9'(chn);
    go_pix = 16'(pixn);
    step();
    step();
    chk("prm_err_clr", 32'(prm_err), 32'd0);
    chk("busy_start", 32'(busy), 32'd1);
    if (stall > 0) begin
      sv = om;
      om = 0;
      repeat (stall) step();
      chk("stall_hs", 32'(n_hs), 32'd8);
      chk("stall_ready", 32'(qif.in_ready), 32'd0);
      chk("stall_fifo", 32'(n_hs - n_out), 32'd8);
      om = sv;
    end
    for (int i = 0; i < 20000 && done_cnt == 0; i++) step();
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $error("FAIL layer_timeout: got no done expected done");
    end
    chk("n_out", 32'(n_out), 32'(chn * pixn));
    chk("sb_empty", 32'(exq.size()), 32'd0);
    chk("done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
    step();
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic bad_start(input int chn, input int pixn);
    go_req = 1'b1;
    go_ch = 9'(chn);
    go_pix = 16'(pixn);
    step();
    chk("bad_ready0", 32'(qif.in_ready), 32'd0);
    step();
    chk("bad_done", 32'(done), 32'd1);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_ready1", 32'(qif.in_ready), 32'd0);
    step();
    chk("bad_done_end", 32'(done), 32'd0);
    chk("bad_ready2", 32'(qif.in_ready), 32'd0);
  endtask

  initial begin
    qif.in_valid = 1'b0;
    qif.in_data = '0;
    qif.out_ready = 1'b0;
    vm = 0;
    om = 0;
    go_ch = '0;
    go_pix = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prm_err", 32'(prm_err), 32'd0);
    chk("rst_in_ready", 32'(qif.in_ready), 32'd0);
    chk("rst_out_valid", 32'(qif.out_valid), 32'd0);
    chk("rst_out_last", 32'(qif.out_last), 32'd0);
    chk("rst_q_acc", 32'(q_acc), 32'd0);
    chk("rst_q_scale", 32'(q_scale), 32'd0);
    chk("rst_q_zp", 32'(q_zp), 32'd0);
    rst = 1'b0;

    prm_write(0, 16'd16384, 4'd14, 8'd0);
    prm_write(1, 16'hC000, 4'd14, 8'd5);
    vm = 1;
    om = 1;
    run_layer(2, 2, 0);

    prm_write(2, 16'd8192, 4'd13, 8'hF0);
    run_layer(3, 10, 40);

    for (int c = 0; c < 256; c++)
      prm_write(c, 16'($urandom), 4'($urandom_range(0, 15)), 8'(c * 7 + 3));
    vm = 2;
    om = 2;
    sneak_at = cyc + 30;
    run_layer(256, 3, 0);
    sneak_at = -1;

    vm = 1;
    om = 1;
    prm_addr = 8'd0;
    prm_scale = 16'h1234;
    prm_shift = 4'd2;
    prm_zp = 8'h77;
    we_at = cyc + 6;
    run_layer(4, 2, 0);
    we_at = -1;
    prm_we = 1'b0;
    chk("prm_err_set", 32'(prm_err), 32'd1);
    run_layer(2, 1, 0);

    vm = 1;
    bad_start(0, 5);
    bad_start(3, 0);
    bad_start(257, 2);

    m_ch = 0; m_pix = 0; m_chn = 4; m_pixn = 4;
    n_hs = 0; done_cnt = 0;
    exq.delete();
    go_req = 1'b1;
    go_ch = 9'd4;
    go_pix = 16'd4;
    for (int i = 0; i < 50 && n_hs == 0; i++) step();
    chk("abort_hs_seen", 32'(n_hs > 0), 32'd1);
    repeat (3) step();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 32'(qif.out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(qif.in_ready), 32'd0);
    pend = 1'b0;
    done_cnt = 0;
    repeat (3) step();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_layer(4, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
